// File: rtl/sysid_checker.sv
// sysid_checker: reads the two words of an Avalon-MM sysid slave (ID at address 0,
// timestamp at address 1) and compares them against the values this build expects.
//
// Ports:
//   clk, reset_n            clock, asynchronous active-low reset
//   start                   request one check sequence (sampled in idle only)
//   avm_address, avm_read   Avalon-MM master request (0 = ID word, 1 = timestamp word)
//   avm_waitrequest         slave stall; a read is accepted when avm_read && !avm_waitrequest
//   avm_readdatavalid       qualifies avm_readdata
//   avm_readdata            returned word
//   busy                    sequence in progress (read or wait phases)
//   done                    one-cycle pulse at the end of every completed sequence
//   pass                    id_ok && ts_ok && !timeout_err, updated together with done
//   id_ok, ts_ok            word matched its expected value
//   timeout_err             a read took TIMEOUT cycles without returning data
//   id_value, ts_value      captured words
module sysid_checker #(
    parameter logic [31:0] EXPECTED_ID = 32'd364094772,
    parameter logic [31:0] EXPECTED_TS = 32'd1426599870,
    parameter int unsigned TIMEOUT     = 255
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    output logic        avm_address,
    output logic        avm_read,
    input  logic        avm_waitrequest,
    input  logic        avm_readdatavalid,
    input  logic [31:0] avm_readdata,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic        id_ok,
    output logic        ts_ok,
    output logic        timeout_err,
    output logic [31:0] id_value,
    output logic [31:0] ts_value
);

    typedef enum logic [2:0] {StIdle, StRdId, StWtId, StRdTs, StWtTs, StFin} state_e;

    // Last counter value a read may reach before it is abandoned.
    localparam logic [7:0] CntLast = 8'(TIMEOUT - 1);

    state_e      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        id_ok_q, id_ok_d, ts_ok_q, ts_ok_d, to_q, to_d, pass_q, pass_d;
    logic [31:0] id_val_q, id_val_d, ts_val_q, ts_val_d;

    logic rd_phase, wt_phase, ts_phase, accept, capture, expired;

    assign rd_phase = (state_q == StRdId) || (state_q == StRdTs);
    assign wt_phase = (state_q == StWtId) || (state_q == StWtTs);
    assign ts_phase = (state_q == StRdTs) || (state_q == StWtTs);
    assign accept   = rd_phase && !avm_waitrequest;
    // Data counts in a read phase only together with its own acceptance (zero-latency slave).
    assign capture  = (accept && avm_readdatavalid) || (wt_phase && avm_readdatavalid);
    // Returned data wins over a timeout landing in the same cycle.
    assign expired  = (rd_phase || wt_phase) && (cnt_q == CntLast) && !capture;

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (start) state_d = StRdId;
            StRdId: begin
                if (capture)      state_d = StRdTs;
                else if (expired) state_d = StFin;
                else if (accept)  state_d = StWtId;
            end
            StWtId: begin
                if (capture)      state_d = StRdTs;
                else if (expired) state_d = StFin;
            end
            StRdTs: begin
                if (capture || expired) state_d = StFin;
                else if (accept)        state_d = StWtTs;
            end
            StWtTs: if (capture || expired) state_d = StFin;
            StFin:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Outputs decoded from state
    always_comb begin
        avm_read    = rd_phase;
        avm_address = ts_phase;
        busy        = rd_phase || wt_phase;
        done        = (state_q == StFin);
    end

    // Counter and result next-state
    always_comb begin
        id_ok_d  = id_ok_q;
        ts_ok_d  = ts_ok_q;
        to_d     = to_q;
        pass_d   = pass_q;
        id_val_d = id_val_q;
        ts_val_d = ts_val_q;

        if ((state_d == StRdId || state_d == StRdTs) && state_d != state_q) begin
            cnt_d = 8'd0;
        end else if (rd_phase || wt_phase) begin
            cnt_d = cnt_q + 8'd1;
        end else begin
            cnt_d = 8'd0;
        end

        if (state_q == StIdle && start) begin
            id_ok_d  = 1'b0;
            ts_ok_d  = 1'b0;
            to_d     = 1'b0;
            pass_d   = 1'b0;
            id_val_d = '0;
            ts_val_d = '0;
        end
        if (capture && !ts_phase) begin
            id_val_d = avm_readdata;
            id_ok_d  = (avm_readdata == EXPECTED_ID);
        end
        if (capture && ts_phase) begin
            ts_val_d = avm_readdata;
            ts_ok_d  = (avm_readdata == EXPECTED_TS);
        end
        if (expired) to_d = 1'b1;
        // pass settles on entry to FIN so it is valid in the done cycle.
        if (state_d == StFin && state_q != StFin) begin
            pass_d = id_ok_d && ts_ok_d && !to_d;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q    <= 8'd0;
            id_ok_q  <= 1'b0;
            ts_ok_q  <= 1'b0;
            to_q     <= 1'b0;
            pass_q   <= 1'b0;
            id_val_q <= '0;
            ts_val_q <= '0;
        end else begin
            cnt_q    <= cnt_d;
            id_ok_q  <= id_ok_d;
            ts_ok_q  <= ts_ok_d;
            to_q     <= to_d;
            pass_q   <= pass_d;
            id_val_q <= id_val_d;
            ts_val_q <= ts_val_d;
        end
    end

    assign pass        = pass_q;
    assign id_ok       = id_ok_q;
    assign ts_ok       = ts_ok_q;
    assign timeout_err = to_q;
    assign id_value    = id_val_q;
    assign ts_value    = ts_val_q;

endmodule
